uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of uart_tx, sharing its 50 MHz clock domain and default 9600 baud.
- Synchronises the asynchronous serial line and detects and validates the start bit.
- Samples each bit at mid-period and presents each received byte with a one-cycle valid strobe.
- Sits at the board RX pin and feeds the host-side consumer logic.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 5208 at defaults), clocks per bit period; derived, not overridden independently.

Ports:
- clk_50M  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- uart_rxd  input  1  asynchronous serial line; idles high.
- read_valid  output  1  one-cycle pulse: read_value holds a newly received good byte.
- read_value  output  8  last correctly framed byte, LSB received first.
- frame_error  output  1  one-cycle pulse: stop bit sampled low.
- parity_error  output  1  one-cycle pulse: parity mismatch; tied 0 unless UART_RX_PARITY_EN.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, all counters 0, read_valid=0, frame_error=0, parity_error=0, busy=0, read_value=8'h00.
  - Both synchroniser flops reset to 1, so reset release never produces a false start.
- Synchroniser: uart_rxd passes through a 2-flop synchroniser; all decisions use its output rxs (2-cycle input latency).
- State machine:
  - IDLE: rxs==0 -> START, clear bit counter.
  - START: count CLKS_PER_BIT/2 cycles (2604 at defaults), then re-sample rxs. rxs==1 -> IDLE (glitch rejected, no pulses). rxs==0 -> DATA.
  - DATA: every CLKS_PER_BIT cycles, sample rxs into the shift register at bit index 0..7, LSB first. After bit 7 -> PARITY if enabled, else STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxs.
    - rxs==1 and no parity fault: load read_value, pulse read_valid for exactly 1 cycle, -> IDLE.
    - rxs==0: pulse frame_error, read_value unchanged, no read_valid, -> BREAK.
  - BREAK: wait for rxs==1, then -> IDLE.
- Timing:
  - Mid-stop sample lands about 9.5 bit periods after the synchronised falling edge; read_valid follows in the next cycle.
  - IDLE is re-entered at mid-stop, so back-to-back frames with zero idle gap are received.
- Counter: 13-bit bit-period counter, reset to 0 at every state transition; no wrap occurs within a bit.
- Reset mid-frame: next cycle state=IDLE; the partial byte is discarded with no pulse.
- read_value is held stable between read_valid pulses.
- No handshake or backpressure: an unconsumed byte is overwritten by the next good frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN
- Defined:
  - Adds a PARITY state between DATA and STOP that samples one extra bit after CLKS_PER_BIT cycles.
  - Even parity: XOR of data plus parity bit must be 0.
  - On mismatch: parity_error pulses in the cycle read_valid would have pulsed; read_valid is suppressed and read_value is unchanged.
  - frame_error still takes priority when the stop bit is low; the two pulses are never asserted together.
- Not defined: 8N1 only; parity_error constant 0; no PARITY state.

Decomposition:
- Shared package uart_pkg:
  - state encoding (IDLE, START, DATA, PARITY, STOP, BREAK);
  - default CLK_FREQ and BAUD;
  - CLKS_PER_BIT computation.
  - The same package serves uart_tx.
- One sub-module: uart_sync2, a 2-flop synchroniser with parameterisable reset value (1 here).
- Everything else stays in uart_rx.

Test Plan:
- Drive 8'h21 as 8N1 at 104166 ns/bit after reset -> exactly one read_valid, read_value=8'h21, frame_error=0.
- Frames 8'h43 then 8'h65 back-to-back with no idle gap -> two read_valid pulses, values 8'h43 then 8'h65 in order.
- 1 us low glitch on idle line -> returns to IDLE after half-bit check; no read_valid or frame_error; busy deasserts within 2610 cycles.
- 8'hA5 sent with stop bit held low for 2 bit periods -> frame_error pulses once, read_value keeps prior 8'h65, no read_valid until a line-high and a new 8'h21 frame.
- Reset asserted at bit 4 of 8'h3C, then clean 8'h5A -> no pulse for the partial byte; read_value=8'h5A with a single read_valid.
- With UART_RX_PARITY_EN:
  - 8'h07 with parity bit 1 -> read_valid, read_value=8'h07.
  - 8'h07 with parity bit 0 -> parity_error pulse, no read_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line settings and bit-period helper.
// Used by both uart_rx and uart_tx.
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_FREQ = 50_000_000;
  localparam int unsigned DEFAULT_BAUD     = 9600;
  localparam int unsigned CNT_W            = 13;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } uart_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// ResetVal sets what both flops hold during reset.
module uart_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and single-cycle result strobes.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int unsigned BAUD     = DEFAULT_BAUD
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       read_valid,
  output logic [7:0] read_value,
  output logic       frame_error,
  output logic       parity_error,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [CNT_W-1:0] BitLast  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HalfLast = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic rxs;

  uart_sync2 #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk     (clk_50M),
    .reset   (reset),
    .async_in(uart_rxd),
    .sync_out(rxs)
  );

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       read_value_q, read_value_d;
  logic             read_valid_q, read_valid_d;
  logic             frame_error_q, frame_error_d;
  logic             par_ok;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic parity_error_q, parity_error_d;

  // Even parity: data bits plus the received parity bit must XOR to zero.
  assign par_ok = ~(^shift_q ^ par_q);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk_50M) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      read_value_q  <= 8'h00;
      read_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q          <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      read_value_q  <= read_value_d;
      read_valid_q  <= read_valid_d;
      frame_error_q <= frame_error_d;
`ifdef UART_RX_PARITY_EN
      par_q          <= par_d;
      parity_error_q <= parity_error_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + CNT_W'(1);
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    read_value_d  = read_value_q;
    read_valid_d  = 1'b0;
    frame_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d          = par_q;
    parity_error_d = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rxs) begin
          state_d   = StStart;
          bit_idx_d = '0;
        end
      end

      // Re-check the line at mid start bit so short glitches are ignored.
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          state_d = rxs ? StIdle : StData;
        end
      end

      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d     = '0;
          shift_d   = {rxs, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          par_d   = rxs;
          state_d = StStop;
        end
      end
`endif

      // Return to idle at mid stop bit so a following start edge is not missed.
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = StIdle;
            if (par_ok) begin
              read_value_d = shift_q;
              read_valid_d = 1'b1;
            end else begin
`ifdef UART_RX_PARITY_EN
              parity_error_d = 1'b1;
`endif
            end
          end else begin
            frame_error_d = 1'b1;
            state_d       = StBreak;
          end
        end
      end

      StBreak: begin
        cnt_d = '0;
        if (rxs) state_d = StIdle;
      end

      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  assign read_valid  = read_valid_q;
  assign read_value  = read_value_q;
  assign frame_error = frame_error_q;
  assign busy        = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign parity_error = parity_error_q;
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx, run at 32 clocks per bit to keep frames short.
// Parity cases are compiled in when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int unsigned ClkFreq = 50_000_000;
  localparam int unsigned Baud    = 1_562_500;
  localparam int unsigned Cpb     = ClkFreq / Baud;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned PreStopBits = 10;
`else
  localparam int unsigned PreStopBits = 9;
`endif

  logic       clk_50M = 1'b0;
  logic       reset;
  logic       uart_rxd;
  logic       read_valid;
  logic [7:0] read_value;
  logic       frame_error;
  logic       parity_error;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int         n_valid = 0;
  int         n_fe    = 0;
  int         n_pe    = 0;
  logic [7:0] vals[$];

  always #10 clk_50M = ~clk_50M;

  uart_rx #(
    .CLK_FREQ(ClkFreq),
    .BAUD    (Baud)
  ) dut (
    .clk_50M     (clk_50M),
    .reset       (reset),
    .uart_rxd    (uart_rxd),
    .read_valid  (read_valid),
    .read_value  (read_value),
    .frame_error (frame_error),
    .parity_error(parity_error),
    .busy        (busy)
  );

  // Counting every high cycle also verifies that each strobe lasts one cycle.
  always @(negedge clk_50M) begin
    if (read_valid) begin
      n_valid++;
      vals.push_back(read_value);
    end
    if (frame_error) n_fe++;
    if (parity_error) n_pe++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int unsigned n_bits);
    uart_rxd = b;
    repeat (n_bits * Cpb) @(negedge clk_50M);
  endtask

  task automatic send_raw(input logic [7:0] data, input logic par, input logic stop,
                          input int unsigned stop_len);
    logic [9:0] frame;
    frame = {par, data, 1'b0};
    for (int i = 0; i < int'(PreStopBits); i++) drive_bit(frame[i], 1);
    drive_bit(stop, stop_len);
    uart_rxd = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data);
    send_raw(data, ^data, 1'b1, 1);
  endtask

  int v0, f0, p0, q0;
  int wait_cnt;

  initial begin
    uart_rxd = 1'b1;
    reset    = 1'b1;
    repeat (5) @(negedge clk_50M);
    reset = 1'b0;
    @(negedge clk_50M);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_valid", read_valid, 0);
    check_eq("reset_fe", frame_error, 0);
    check_eq("reset_pe", parity_error, 0);
    check_eq("reset_value", read_value, 8'h00);
    drive_bit(1'b1, 1);

    // Single clean frame
    v0 = n_valid; f0 = n_fe; q0 = vals.size();
    send_frame(8'h21);
    drive_bit(1'b1, 2);
    check_eq("t1_valid_cnt", n_valid - v0, 1);
    check_eq("t1_fe_cnt", n_fe - f0, 0);
    check_eq("t1_value", (vals.size() > q0) ? vals[q0] : 8'hxx, 8'h21);
    check_eq("t1_held", read_value, 8'h21);

    // Back-to-back frames with no idle gap
    v0 = n_valid; q0 = vals.size();
    send_frame(8'h43);
    send_frame(8'h65);
    drive_bit(1'b1, 2);
    check_eq("t2_valid_cnt", n_valid - v0, 2);
    check_eq("t2_first", (vals.size() > q0) ? vals[q0] : 8'hxx, 8'h43);
    check_eq("t2_second", (vals.size() > q0 + 1) ? vals[q0+1] : 8'hxx, 8'h65);

    // Short low glitch must be rejected at the half-bit check
    v0 = n_valid; f0 = n_fe;
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk_50M);
    uart_rxd = 1'b1;
    check_eq("t3_busy_rise", busy, 1);
    wait_cnt = 0;
    while (busy && wait_cnt < 2610) begin
      @(negedge clk_50M);
      wait_cnt++;
    end
    check_eq("t3_busy_fall", busy, 0);
    drive_bit(1'b1, 2);
    check_eq("t3_valid_cnt", n_valid - v0, 0);
    check_eq("t3_fe_cnt", n_fe - f0, 0);

    // Stop bit held low: one frame error, value retained, then recovery
    v0 = n_valid; f0 = n_fe;
    send_raw(8'hA5, ^8'hA5, 1'b0, 2);
    check_eq("t4_fe_cnt", n_fe - f0, 1);
    check_eq("t4_valid_cnt", n_valid - v0, 0);
    check_eq("t4_value_kept", read_value, 8'h65);
    drive_bit(1'b1, 1);
    send_frame(8'h21);
    drive_bit(1'b1, 2);
    check_eq("t4_recover_cnt", n_valid - v0, 1);
    check_eq("t4_recover_val", read_value, 8'h21);

    // Reset in the middle of bit 4, then a clean frame
    v0 = n_valid; f0 = n_fe; q0 = vals.size();
    drive_bit(1'b0, 1);
    for (int i = 0; i < 4; i++) drive_bit(((8'h3C >> i) & 8'h01) != 0, 1);
    uart_rxd = 1'b1;
    repeat (Cpb / 2) @(negedge clk_50M);
    reset = 1'b1;
    @(negedge clk_50M);
    check_eq("t5_busy_reset", busy, 0);
    repeat (2) @(negedge clk_50M);
    reset = 1'b0;
    drive_bit(1'b1, 1);
    send_frame(8'h5A);
    drive_bit(1'b1, 2);
    check_eq("t5_valid_cnt", n_valid - v0, 1);
    check_eq("t5_value", (vals.size() > q0) ? vals[q0] : 8'hxx, 8'h5A);
    check_eq("t5_fe_cnt", n_fe - f0, 0);

`ifdef UART_RX_PARITY_EN
    v0 = n_valid; p0 = n_pe;
    send_raw(8'h07, 1'b1, 1'b1, 1);
    drive_bit(1'b1, 2);
    check_eq("p1_valid_cnt", n_valid - v0, 1);
    check_eq("p1_value", read_value, 8'h07);
    check_eq("p1_pe_cnt", n_pe - p0, 0);

    v0 = n_valid; p0 = n_pe;
    send_raw(8'h5A, 1'b0, 1'b1, 1);
    drive_bit(1'b1, 1);
    v0 = n_valid; p0 = n_pe;
    send_raw(8'h07, 1'b0, 1'b1, 1);
    drive_bit(1'b1, 2);
    check_eq("p2_pe_cnt", n_pe - p0, 1);
    check_eq("p2_valid_cnt", n_valid - v0, 0);
    check_eq("p2_value_kept", read_value, 8'h5A);
`else
    p0 = n_pe;
    send_raw(8'h07, 1'b0, 1'b1, 1);
    drive_bit(1'b1, 2);
    check_eq("np_pe_cnt", n_pe - p0, 0);
    check_eq("np_value", read_value, 8'h07);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
